eval_latency_sm: RTL and testbench



---
 rtl/eval_latency_sm.sv | 110 +++++++++++
 tb/tb_eval_latency_sm.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/eval_latency_sm.sv
// rtl/eval_latency_sm.sv - fixed-latency valid tracker for a pipelined board evaluator
// Optional EVAL_LATENCY_BUSY_EN adds busy and overrun_count outputs.
module eval_latency_sm #(
  parameter int LATENCY_COUNT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       board_valid,
  input  logic       clear_eval,
  output logic       eval_valid
`ifdef EVAL_LATENCY_BUSY_EN
  ,
  output logic       busy,
  output logic [7:0] overrun_count
`endif
);

  localparam int CW = $clog2(LATENCY_COUNT + 1);
  localparam logic [CW-1:0] LOAD = CW'(LATENCY_COUNT - 1);

  generate
    if (LATENCY_COUNT < 1 || LATENCY_COUNT > 255) begin : g_bad_latency
      $fatal(1, "eval_latency_sm: LATENCY_COUNT must be within 1..255");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            eval_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      eval_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      eval_valid <= eval_nxt;
    end
  end

  // A new board always wins, even over clear_eval; only the newest board is tracked.
  // LATENCY_COUNT==1 loads cnt=0, so the very next edge reaches DONE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    eval_nxt  = eval_valid;
    case (state)
      IDLE: begin
        eval_nxt = 1'b0;
        if (board_valid) begin
          state_nxt = COUNT;
          cnt_nxt   = LOAD;
        end
      end
      COUNT: begin
        eval_nxt = 1'b0;
        if (board_valid) begin
          cnt_nxt = LOAD;
        end else if (clear_eval) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = DONE;
          eval_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      DONE: begin
        eval_nxt = 1'b1;
        if (board_valid) begin
          state_nxt = COUNT;
          cnt_nxt   = LOAD;
          eval_nxt  = 1'b0;
        end else if (clear_eval) begin
          state_nxt = IDLE;
          eval_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        eval_nxt  = 1'b0;
      end
    endcase
  end

`ifdef EVAL_LATENCY_BUSY_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy          <= 1'b0;
      overrun_count <= 8'd0;
    end else begin
      busy <= (state_nxt == COUNT);
      // Each board arriving mid-count discards an in-flight one; saturate at 255.
      if (board_valid && state == COUNT && overrun_count != 8'hFF)
        overrun_count <= overrun_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eval_latency_sm.sv
// tb/tb_eval_latency_sm.sv - directed bench for eval_latency_sm (LATENCY_COUNT 11 and 1)
// Checks busy/overrun_count too when EVAL_LATENCY_BUSY_EN is defined.
module tb_eval_latency_sm;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic board_valid = 1'b0;
  logic clear_eval = 1'b0;
  logic ev11, ev1;
  int   errors = 0;
  int   checks = 0;
  logic seen_high;
`ifdef EVAL_LATENCY_BUSY_EN
  logic       busy11, busy1;
  logic [7:0] ovr11, ovr1;
`endif

  always #5 clk = ~clk;

  eval_latency_sm #(.LATENCY_COUNT(11)) dut11 (
    .clk(clk), .reset(reset), .board_valid(board_valid), .clear_eval(clear_eval),
    .eval_valid(ev11)
`ifdef EVAL_LATENCY_BUSY_EN
    , .busy(busy11), .overrun_count(ovr11)
`endif
  );

  eval_latency_sm #(.LATENCY_COUNT(1)) dut1 (
    .clk(clk), .reset(reset), .board_valid(board_valid), .clear_eval(clear_eval),
    .eval_valid(ev1)
`ifdef EVAL_LATENCY_BUSY_EN
    , .busy(busy1), .overrun_count(ovr1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Drive inputs for one edge, then sample 1 time unit after it.
  task automatic step(input logic bv, input logic ce);
    board_valid = bv;
    clear_eval  = ce;
    @(posedge clk);
    #1;
    board_valid = 1'b0;
    clear_eval  = 1'b0;
  endtask

  initial begin
    // Test 1: reset, single board, hold, clear
    reset = 1'b0;
    repeat (3) step(0, 0);
    check("reset_eval11", ev11, 0);
    check("reset_eval1", ev1, 0);
`ifdef EVAL_LATENCY_BUSY_EN
    check("reset_busy", busy11, 0);
    check("reset_overrun", ovr11, 0);
`endif
    reset = 1'b1;
    step(1, 0);                                  // edge 0
    for (int e = 1; e <= 10; e++) begin
      step(0, 0);
      if (e == 1 || e == 10) check($sformatf("t1_low_e%0d", e), ev11, 0);
    end
    step(0, 0);                                  // edge 11
    check("t1_high_e11", ev11, 1);
    repeat (9) step(0, 0);                       // edge 20
    check("t1_hold_e20", ev11, 1);
    step(0, 1);                                  // edge 21
    check("t1_clear_e21", ev11, 0);

    // Test 2: restart at edge 5 moves completion to edge 16
    step(1, 0);                                  // edge 0
    repeat (4) step(0, 0);
    step(1, 0);                                  // edge 5
    repeat (10) step(0, 0);                      // edge 15
    check("t2_low_e15", ev11, 0);
`ifdef EVAL_LATENCY_BUSY_EN
    check("t2_busy_e15", busy11, 1);
`endif
    step(0, 0);                                  // edge 16
    check("t2_high_e16", ev11, 1);
`ifdef EVAL_LATENCY_BUSY_EN
    check("t2_busy_e16", busy11, 0);
    check("t2_overrun", ovr11, 1);
`endif
    step(0, 1);

    // Test 3: clear during count cancels it
    step(1, 0);                                  // edge 0
    repeat (3) step(0, 0);
    step(0, 1);                                  // edge 4
    seen_high = 1'b0;
    for (int e = 5; e <= 30; e++) begin
      step(0, 0);
      if (ev11) seen_high = 1'b1;
    end
    check("t3_never_high", seen_high, 0);
`ifdef EVAL_LATENCY_BUSY_EN
    check("t3_idle_busy", busy11, 0);
`endif

    // Test 4: board and clear together in DONE restart the count
    step(1, 0);
    repeat (11) step(0, 0);
    check("t4_done", ev11, 1);
    step(1, 1);                                  // edge N
    check("t4_drop_N", ev11, 0);
    repeat (10) step(0, 0);
    check("t4_low_N10", ev11, 0);
    step(0, 0);
    check("t4_high_N11", ev11, 1);
    step(0, 1);

    // Test 5: reset mid-count aborts it
    step(1, 0);                                  // edge 0
    repeat (5) step(0, 0);
    reset = 1'b0;
    step(0, 0);                                  // edge 6
    reset = 1'b1;
    seen_high = 1'b0;
    for (int e = 7; e <= 30; e++) begin
      step(0, 0);
      if (ev11) seen_high = 1'b1;
    end
    check("t5_never_high", seen_high, 0);
`ifdef EVAL_LATENCY_BUSY_EN
    check("t5_overrun_reset", ovr11, 0);
`endif
    step(1, 0);
    repeat (10) step(0, 0);
    check("t5_low_10", ev11, 0);
    step(0, 0);
    check("t5_high_11", ev11, 1);

    // Test 6: LATENCY_COUNT=1
    step(0, 1);
    check("t6_idle", ev1, 0);
    step(1, 0);                                  // edge 0
    check("t6_low_e0", ev1, 0);
    step(0, 0);                                  // edge 1
    check("t6_high_e1", ev1, 1);
    step(0, 0);                                  // edge 2
    check("t6_hold_e2", ev1, 1);
    step(0, 1);                                  // edge 3
    check("t6_clear_e3", ev1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
